// File: rtl/bram_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_loader_pkg
// Description : Shared types and constants for the BRAM byte loader.
// Revision    : 1.0 - initial release
// ============================================================================
package bram_loader_pkg;

    // Byte lanes per 32-bit BRAM word
    localparam int LANES = 4;

    // Loader control states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Byte-count width: a word address plus two bits of byte offset
    function automatic int len_width(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_lane_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_lane_packer
// Description : Little-endian byte-to-word accumulator with per-lane mask.
//               Exposes the word and mask as they would be after the current
//               byte is pushed, so the owner can register them straight onto
//               the BRAM port on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_lane_packer
    import bram_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clear,
    input  logic                 i_push,
    input  logic [7:0]           i_byte,
    output logic [8*LANES-1:0]   o_acc_nxt,
    output logic [LANES-1:0]     o_mask_nxt,
    output logic                 o_last_lane
);

    localparam logic [1:0] c_LAST_LANE = 2'(LANES - 1);

    logic [8*LANES-1:0] r_acc;
    logic [LANES-1:0]   r_mask;
    logic [1:0]         r_lane;

    logic [8*LANES-1:0] w_byte_word;
    logic [LANES-1:0]   w_lane_bit;

    // Place the incoming byte in its lane and merge with what is held
    always_comb begin
        w_byte_word = {{(8*(LANES-1)){1'b0}}, i_byte} << {r_lane, 3'b000};
        w_lane_bit  = {{(LANES-1){1'b0}}, 1'b1} << r_lane;
        o_acc_nxt   = r_acc | w_byte_word;
        o_mask_nxt  = r_mask | w_lane_bit;
        o_last_lane = (r_lane == c_LAST_LANE);
    end

    // Accumulator, mask and lane index; clear wins over push
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_mask <= '0;
            r_lane <= '0;
        end else if (i_clear) begin
            r_acc  <= '0;
            r_mask <= '0;
            r_lane <= '0;
        end else if (i_push) begin
            r_acc  <= o_acc_nxt;
            r_mask <= o_mask_nxt;
            r_lane <= r_lane + 2'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_byte_loader.sv
`default_nettype none
// ============================================================================
// Module      : bram_byte_loader
// Description : Streams bytes into a 32-bit byte-addressable BRAM port, one
//               masked write per packed word, flushing a final partial word.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_byte_loader
    import bram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH-1:0]            i_base_addr,
    input  logic [len_width(ADDR_WIDTH)-1:0] i_length,
    input  logic                             i_byte_valid,
    input  logic [7:0]                       i_byte_data,
    output logic                             o_byte_ready,
    output logic                             o_busy,
    output logic                             o_done,
    output logic [7:0]                       o_checksum,
    output logic                             o_bram_clken,
    output logic [ADDR_WIDTH-1:0]            o_bram_addr,
    output logic [LANES-1:0]                 o_bram_we,
    output logic [8*LANES-1:0]               o_bram_data
);

    localparam int                    LEN_W      = len_width(ADDR_WIDTH);
    localparam logic [LEN_W-1:0]      c_REM_ONE  = LEN_W'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE  = ADDR_WIDTH'(1);

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic [LEN_W-1:0]        r_remaining;
    logic [7:0]              r_checksum;
    logic                    r_byte_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_bram_clken;
    logic [ADDR_WIDTH-1:0]   r_bram_addr;
    logic [LANES-1:0]        r_bram_we;
    logic [8*LANES-1:0]      r_bram_data;

    logic                    w_accept;
    logic                    w_clear;
    logic [8*LANES-1:0]      w_acc_nxt;
    logic [LANES-1:0]        w_mask_nxt;
    logic                    w_last_lane;

    // Handshake and packer clear: a fresh word starts on a new load and after each write
    always_comb begin
        w_accept = i_byte_valid & r_byte_ready;
        w_clear  = ((r_state == S_IDLE) && i_start) || (r_state == S_WRITE);
    end

    byte_lane_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_clear),
        .i_push      (w_accept),
        .i_byte      (i_byte_data),
        .o_acc_nxt   (w_acc_nxt),
        .o_mask_nxt  (w_mask_nxt),
        .o_last_lane (w_last_lane)
    );

    // Load sequencer with all port outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_remaining  <= '0;
            r_checksum   <= '0;
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_bram_clken <= 1'b0;
            r_bram_addr  <= '0;
            r_bram_we    <= '0;
            r_bram_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_ptr       <= i_base_addr;
                        r_remaining <= i_length;
                        r_checksum  <= '0;
                        r_busy      <= 1'b1;
                        if (i_length == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= S_FILL;
                            r_byte_ready <= 1'b1;
                        end
                    end
                end

                S_FILL: begin
                    if (w_accept) begin
                        r_checksum  <= r_checksum + i_byte_data;
                        r_remaining <= r_remaining - c_REM_ONE;
                        // Word is complete, or the load ends mid-word
                        if (w_last_lane || (r_remaining == c_REM_ONE)) begin
                            r_state      <= S_WRITE;
                            r_byte_ready <= 1'b0;
                            r_bram_clken <= 1'b1;
                            r_bram_addr  <= r_ptr;
                            r_bram_we    <= w_mask_nxt;
                            r_bram_data  <= w_acc_nxt;
                        end
                    end
                end

                S_WRITE: begin
                    r_bram_clken <= 1'b0;
                    r_bram_addr  <= '0;
                    r_bram_we    <= '0;
                    r_bram_data  <= '0;
                    r_ptr        <= r_ptr + c_PTR_ONE;
                    if (r_remaining == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= S_FILL;
                        r_byte_ready <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_byte_ready = r_byte_ready;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_checksum   = r_checksum;
    assign o_bram_clken = r_bram_clken;
    assign o_bram_addr  = r_bram_addr;
    assign o_bram_we    = r_bram_we;
    assign o_bram_data  = r_bram_data;

endmodule
`default_nettype wire

// File: tb/tb_bram_byte_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bram_byte_loader
// Description : Directed self-checking bench for bram_byte_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_byte_loader;

    localparam int AW = 12;
    localparam int LW = AW + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [AW-1:0] i_base_addr;
    logic [LW-1:0] i_length;
    logic          i_byte_valid;
    logic [7:0]    i_byte_data;
    logic          o_byte_ready;
    logic          o_busy;
    logic          o_done;
    logic [7:0]    o_checksum;
    logic          o_bram_clken;
    logic [AW-1:0] o_bram_addr;
    logic [3:0]    o_bram_we;
    logic [31:0]   o_bram_data;

    bram_byte_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_length     (i_length),
        .i_byte_valid (i_byte_valid),
        .i_byte_data  (i_byte_data),
        .o_byte_ready (o_byte_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_checksum   (o_checksum),
        .o_bram_clken (o_bram_clken),
        .o_bram_addr  (o_bram_addr),
        .o_bram_we    (o_bram_we),
        .o_bram_data  (o_bram_data)
    );

    always #5 clk = ~clk;

    // Byte source: presents src_mem[src_idx] while src_idx < src_lim
    logic [7:0] src_mem [0:255];
    int         src_idx  = 0;
    int         src_lim  = 0;
    logic       tog_mode = 1'b0;
    logic       phase    = 1'b0;

    always @(posedge clk) begin
        phase <= ~phase;
        if (i_byte_valid && o_byte_ready) src_idx <= src_idx + 1;
    end

    assign i_byte_valid = (src_idx < src_lim) && (!tog_mode || phase);
    assign i_byte_data  = src_mem[src_idx[7:0]];

    // Write and done monitor, sampled mid-cycle
    logic [AW-1:0] wr_addr [0:63];
    logic [3:0]    wr_we   [0:63];
    logic [31:0]   wr_data [0:63];
    int            wr_n     = 0;
    int            done_cnt = 0;
    int            cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_bram_clken && wr_n < 64) begin
            wr_addr[wr_n] <= o_bram_addr;
            wr_we[wr_n]   <= o_bram_we;
            wr_data[wr_n] <= o_bram_data;
            wr_n          <= wr_n + 1;
        end
        if (o_done) done_cnt <= done_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int c0, w0, d0, s0, rel;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Load the source and pulse start; c0 marks cycle 1 after start
    task automatic start_load(input logic [AW-1:0] base, input int len, input logic [63:0] bytes);
        for (int i = 0; i < len; i++) src_mem[(src_idx + i) % 256] = bytes[8*i +: 8];
        src_lim = src_idx + len;
        @(negedge clk);
        i_base_addr = base;
        i_length    = LW'(len);
        i_start     = 1'b1;
        w0 = wr_n;
        d0 = done_cnt;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        c0 = cyc;
    endtask

    task automatic wait_done(output int r);
        r = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (o_done) begin
                r = cyc - c0 + 1;
                break;
            end
        end
        if (r < 0) check_val("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_write(input int k, input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d);
        check_val("wr_addr", 32'(wr_addr[w0 + k]), 32'(a));
        check_val("wr_we",   32'(wr_we[w0 + k]),   32'(we));
        check_val("wr_data", wr_data[w0 + k],      d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_length    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready",  32'(o_byte_ready), 32'd0);
        check_val("rst_busy",   32'(o_busy),       32'd0);
        check_val("rst_done",   32'(o_done),       32'd0);
        check_val("rst_csum",   32'(o_checksum),   32'd0);
        check_val("rst_clken",  32'(o_bram_clken), 32'd0);
        check_val("rst_we",     32'(o_bram_we),    32'd0);
        check_val("rst_addr",   32'(o_bram_addr),  32'd0);
        check_val("rst_data",   o_bram_data,       32'd0);
        rst_n = 1'b1;

        // Two full words
        start_load(12'h010, 8, 64'h0807060504030201);
        check_val("t1_ready_lat", 32'(o_byte_ready), 32'd1);
        check_val("t1_busy",      32'(o_busy),       32'd1);
        wait_done(rel);
        check_val("t1_done_cyc", 32'(rel), 32'd11);
        check_val("t1_busy_done", 32'(o_busy), 32'd1);
        check_val("t1_nwr", 32'(wr_n - w0), 32'd2);
        chk_write(0, 12'h010, 4'b1111, 32'h04030201);
        chk_write(1, 12'h011, 4'b1111, 32'h08070605);
        check_val("t1_csum", 32'(o_checksum), 32'h24);

        // Partial final word
        start_load(12'h020, 6, 64'h0000FFEEDDCCBBAA);
        wait_done(rel);
        check_val("t2_done_cyc", 32'(rel), 32'd9);
        repeat (3) @(negedge clk);
        check_val("t2_nwr", 32'(wr_n - w0), 32'd2);
        chk_write(0, 12'h020, 4'b1111, 32'hDDCCBBAA);
        chk_write(1, 12'h021, 4'b0011, 32'h0000FFEE);
        check_val("t2_done_once", 32'(done_cnt - d0), 32'd1);
        check_val("t2_csum", 32'(o_checksum), 32'hFB);
        check_val("t2_idle_busy", 32'(o_busy), 32'd0);

        // Zero length
        start_load(12'h040, 0, 64'h0);
        check_val("t3_ready", 32'(o_byte_ready), 32'd0);
        wait_done(rel);
        check_val("t3_done_cyc", 32'(rel), 32'd1);
        repeat (2) @(negedge clk);
        check_val("t3_nwr", 32'(wr_n - w0), 32'd0);
        check_val("t3_csum", 32'(o_checksum), 32'h00);

        // Address wrap
        start_load(12'hFFF, 8, 64'h1716151413121110);
        wait_done(rel);
        check_val("t4_done_cyc", 32'(rel), 32'd11);
        check_val("t4_nwr", 32'(wr_n - w0), 32'd2);
        chk_write(0, 12'hFFF, 4'b1111, 32'h13121110);
        chk_write(1, 12'h000, 4'b1111, 32'h17161514);
        check_val("t4_csum", 32'(o_checksum), 32'h9C);

        // Toggling source plus a start pulse mid-load
        tog_mode = 1'b1;
        start_load(12'h100, 4, 64'h44332211);
        repeat (3) @(negedge clk);
        i_base_addr = 12'h200;
        i_length    = LW'(8);
        i_start     = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(rel);
        repeat (3) @(negedge clk);
        check_val("t5_nwr", 32'(wr_n - w0), 32'd1);
        chk_write(0, 12'h100, 4'b1111, 32'h44332211);
        check_val("t5_csum", 32'(o_checksum), 32'hAA);
        check_val("t5_done_once", 32'(done_cnt - d0), 32'd1);
        tog_mode = 1'b0;

        // Reset mid-load, then a clean reload
        s0 = src_idx;
        start_load(12'h300, 4, 64'h04030201);
        for (int k = 0; k < 50; k++) begin
            if (src_idx - s0 == 3) break;
            @(negedge clk);
        end
        check_val("t6_three_bytes", 32'(src_idx - s0), 32'd3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("t6_rst_ready", 32'(o_byte_ready), 32'd0);
        check_val("t6_rst_busy",  32'(o_busy),       32'd0);
        check_val("t6_rst_csum",  32'(o_checksum),   32'd0);
        check_val("t6_rst_clken", 32'(o_bram_clken), 32'd0);
        check_val("t6_rst_we",    32'(o_bram_we),    32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("t6_no_write", 32'(wr_n - w0), 32'd0);
        check_val("t6_no_done", 32'(done_cnt - d0), 32'd0);
        start_load(12'h301, 4, 64'h08070605);
        wait_done(rel);
        check_val("t6_done_cyc", 32'(rel), 32'd6);
        check_val("t6_nwr", 32'(wr_n - w0), 32'd1);
        chk_write(0, 12'h301, 4'b1111, 32'h08070605);
        check_val("t6_csum", 32'(o_checksum), 32'h1A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
